// File: rtl/strobe_bank_loader_if.sv
// Write/commit/status bundle for strobe_bank_loader.
// STROBE_LOADER_READBACK_EN adds the rd_en/rd_data shadow read port.
interface strobe_bank_loader_if #(
    parameter int ADDRESS_SIZE = 10,
    parameter int DATA_SIZE    = 8,
    parameter int NB_TARGETS   = 6,
    parameter int STROBE_W     = 68
) ();
    logic                           wr_valid;
    logic                           wr_ready;
    logic [ADDRESS_SIZE-1:0]        address;
    logic [DATA_SIZE-1:0]           wr_data;
    logic                           commit;
    logic                           busy;
    logic                           err_clr;
    logic                           error;
    logic [NB_TARGETS-1:0]          updated;
    logic [NB_TARGETS*STROBE_W-1:0] strobe_out;
`ifdef STROBE_LOADER_READBACK_EN
    logic                           rd_en;
    logic [DATA_SIZE-1:0]           rd_data;

    modport master (
        output wr_valid, address, wr_data, commit, err_clr, rd_en,
        input  wr_ready, busy, error, updated, strobe_out, rd_data
    );
    modport slave (
        input  wr_valid, address, wr_data, commit, err_clr, rd_en,
        output wr_ready, busy, error, updated, strobe_out, rd_data
    );
`else
    modport master (
        output wr_valid, address, wr_data, commit, err_clr,
        input  wr_ready, busy, error, updated, strobe_out
    );
    modport slave (
        input  wr_valid, address, wr_data, commit, err_clr,
        output wr_ready, busy, error, updated, strobe_out
    );
`endif
endinterface

// File: rtl/strobe_bank_loader.sv
// Double-buffered strobe configuration loader: byte writes fill shadows, COMMIT scans dirty
// shadows into the live strobes one target per cycle. Optional shadow readback: STROBE_LOADER_READBACK_EN.
module strobe_bank_loader #(
    parameter int ADDRESS_SIZE = 10,
    parameter int DATA_SIZE    = 8,
    parameter int NB_TARGETS   = 6,
    parameter int STROBE_W     = 68
) (
    input logic                 clk,
    input logic                 rst_n,
    strobe_bank_loader_if.slave bus
);
    localparam int TGT_W    = (NB_TARGETS > 1) ? $clog2(NB_TARGETS) : 1;
    localparam int NB_BYTES = (STROBE_W + DATA_SIZE - 1) / DATA_SIZE;
    localparam int IDX_W    = ADDRESS_SIZE - TGT_W;
    localparam int PAD_W    = NB_BYTES * DATA_SIZE;
    localparam logic [TGT_W-1:0] LAST_T = TGT_W'(NB_TARGETS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state;
    logic [TGT_W-1:0]      t;
    logic [STROBE_W-1:0]   shadow [NB_TARGETS];
    logic [NB_TARGETS-1:0] dirty;

    logic [TGT_W-1:0] addr_tgt;
    logic [IDX_W-1:0] addr_idx;
    logic             addr_ok;
    logic             wr_fire;
    logic [TGT_W-1:0] tgt_safe;
    logic [IDX_W-1:0] idx_safe;
    logic [PAD_W-1:0] current;
    logic [PAD_W-1:0] merged;

    assign addr_tgt = bus.address[ADDRESS_SIZE-1 -: TGT_W];
    assign addr_idx = bus.address[IDX_W-1:0];
    assign addr_ok  = (32'(addr_tgt) < NB_TARGETS) && (32'(addr_idx) < NB_BYTES);
    assign wr_fire  = bus.wr_valid && bus.wr_ready;
    assign tgt_safe = addr_ok ? addr_tgt : '0;
    assign idx_safe = addr_ok ? addr_idx : '0;
    assign current  = PAD_W'(shadow[tgt_safe]);

    // Padding the shadow to whole bytes lets the top partial byte drop its excess bits on truncation.
    always_comb begin
        merged = current;
        merged[idx_safe*DATA_SIZE +: DATA_SIZE] = bus.wr_data;
    end

    // NOTE: the shadow and live arrays are reset flops, not RAM, so a reset mid-scan wipes
    // every word at once and no partially committed configuration survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            t              <= '0;
            dirty          <= '0;
            for (int i = 0; i < NB_TARGETS; i++) shadow[i] <= '0;
            bus.strobe_out <= '0;
            bus.updated    <= '0;
            bus.error      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.wr_ready   <= 1'b1;
        end else begin
            bus.updated <= '0;
            if (wr_fire && !addr_ok)
                bus.error <= 1'b1;
            else if (bus.err_clr)
                bus.error <= 1'b0;

            case (state)
                IDLE: begin
                    if (wr_fire && addr_ok) begin
                        shadow[tgt_safe] <= merged[STROBE_W-1:0];
                        dirty[tgt_safe]  <= 1'b1;
                    end
                    // wr_ready is a registered copy of the state so wr_valid never reaches it combinationally.
                    if (bus.commit) begin
                        state        <= SCAN;
                        t            <= '0;
                        bus.busy     <= 1'b1;
                        bus.wr_ready <= 1'b0;
                    end
                end
                SCAN: begin
                    if (dirty[t]) begin
                        bus.strobe_out[t*STROBE_W +: STROBE_W] <= shadow[t];
                        bus.updated[t] <= 1'b1;
                        dirty[t]       <= 1'b0;
                    end
                    if (t == LAST_T) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.wr_ready <= 1'b1;
                    end else begin
                        t <= t + TGT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STROBE_LOADER_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.rd_data <= '0;
        else if (bus.rd_en)
            bus.rd_data <= addr_ok ? current[idx_safe*DATA_SIZE +: DATA_SIZE] : '0;
    end
`endif
endmodule

// File: tb/tb_strobe_bank_loader.sv
// Randomised self-checking bench for strobe_bank_loader against a byte/bit-level reference model.
module tb_strobe_bank_loader;
    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int NB  = 6;
    localparam int SW  = 68;
    localparam int IW  = 7;
    localparam int NBY = 9;
    localparam int LW  = NB * SW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    strobe_bank_loader_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .NB_TARGETS(NB), .STROBE_W(SW)) bus ();

    strobe_bank_loader #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .NB_TARGETS(NB), .STROBE_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [SW-1:0] sh_m [NB];
    logic [LW-1:0] live_m;
    logic [NB-1:0] dirty_m;
    logic          err_m;

    task automatic check(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] mk_addr(int tgt, int idx);
        return AW'((tgt << IW) | idx);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NB; i++) sh_m[i] = '0;
        live_m  = '0;
        dirty_m = '0;
        err_m   = 1'b0;
    endtask

    task automatic model_write(int tgt, int idx, logic [DW-1:0] d, bit clr);
        if (tgt < NB && idx < NBY) begin
            for (int b = 0; b < DW; b++)
                if (idx * DW + b < SW) sh_m[tgt][idx*DW + b] = d[b];
            dirty_m[tgt] = 1'b1;
            if (clr) err_m = 1'b0;
        end else begin
            err_m = 1'b1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic do_write(int tgt, int idx, logic [DW-1:0] d);
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.address  = mk_addr(tgt, idx);
        bus.wr_data  = d;
        while (!bus.wr_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("wr_ready_timeout", 0, 1);
        step();
        model_write(tgt, idx, d, bus.err_clr);
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_clear_err();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic do_commit(string tag, bit co_wr, int tgt, int idx, logic [DW-1:0] d);
        logic [NB-1:0] exp_mask;
        logic [NB-1:0] acc = '0;
        int n = 0;
        bus.commit = 1'b1;
        if (co_wr) begin
            bus.wr_valid = 1'b1;
            bus.address  = mk_addr(tgt, idx);
            bus.wr_data  = d;
        end
        step();
        bus.commit   = 1'b0;
        bus.wr_valid = 1'b0;
        if (co_wr) model_write(tgt, idx, d, 1'b0);
        exp_mask = dirty_m;
        for (int i = 0; i < NB; i++)
            if (dirty_m[i]) live_m[i*SW +: SW] = sh_m[i];
        dirty_m = '0;
        while (bus.busy && n < 20) begin
            acc |= bus.updated;
            n++;
            step();
        end
        acc |= bus.updated;
        check({tag, "_busy_cycles"}, LW'(n), LW'(6));
        check({tag, "_updated"}, LW'(acc), LW'(exp_mask));
        check({tag, "_live"}, bus.strobe_out, live_m);
        step();
        check({tag, "_updated_idle"}, LW'(bus.updated), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [NB-1:0] acc;
        bus.wr_valid = 1'b0;
        bus.address  = '0;
        bus.wr_data  = '0;
        bus.commit   = 1'b0;
        bus.err_clr  = 1'b0;
`ifdef STROBE_LOADER_READBACK_EN
        bus.rd_en    = 1'b0;
`endif
        model_clear();
        apply_reset();

        check("rst_ready", LW'(bus.wr_ready), LW'(1));
        check("rst_busy", LW'(bus.busy), '0);
        check("rst_error", LW'(bus.error), '0);
        check("rst_updated", LW'(bus.updated), '0);
        check("rst_live", bus.strobe_out, '0);

        // Full target 0 with truncated top byte
        for (int i = 0; i < NBY; i++) do_write(0, i, 8'hA5);
        do_commit("t1", 1'b0, 0, 0, '0);
        check("t1_word0", LW'(bus.strobe_out[67:0]), LW'(68'h5_A5A5_A5A5_A5A5_A5A5));

        // Single byte in the last target
        do_write(5, 3, 8'h3C);
        do_commit("t2", 1'b0, 0, 0, '0);
        check("t2_byte", LW'(bus.strobe_out[5*68+24 +: 8]), LW'(8'h3C));
        check("t2_word0_kept", LW'(bus.strobe_out[67:0]), LW'(68'h5_A5A5_A5A5_A5A5_A5A5));

        // Out-of-range target and index
        do_write(6, 0, 8'hFF);
        check("t3_err_tgt", LW'(bus.error), LW'(err_m));
        do_write(0, 9, 8'hFF);
        check("t3_err_idx", LW'(bus.error), LW'(err_m));
        do_commit("t3", 1'b0, 0, 0, '0);
        do_clear_err();
        check("t3_err_clr", LW'(bus.error), LW'(err_m));
        bus.err_clr = 1'b1;
        do_write(7, 0, 8'h12);
        bus.err_clr = 1'b0;
        check("t3_err_wins", LW'(bus.error), LW'(err_m));
        do_clear_err();

        // Write held during scan, plus a second commit mid-scan
        do_write(1, 0, 8'h5A);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        exp_sync: begin
            logic [NB-1:0] em;
            em = dirty_m;
            for (int i = 0; i < NB; i++) if (dirty_m[i]) live_m[i*SW +: SW] = sh_m[i];
            dirty_m = '0;
            bus.wr_valid = 1'b1;
            bus.address  = mk_addr(2, 0);
            bus.wr_data  = 8'h11;
            n = 0;
            acc = '0;
            while (bus.busy && n < 20) begin
                check("t4_ready_low", LW'(bus.wr_ready), '0);
                acc |= bus.updated;
                bus.commit = (n == 2);
                n++;
                step();
            end
            bus.commit = 1'b0;
            acc |= bus.updated;
            check("t4_busy_cycles", LW'(n), LW'(6));
            check("t4_updated", LW'(acc), LW'(em));
            check("t4_ready_idle", LW'(bus.wr_ready), LW'(1));
            step();
            model_write(2, 0, 8'h11, 1'b0);
            bus.wr_valid = 1'b0;
            check("t4_no_requeue", LW'(bus.busy), '0);
        end
        do_commit("t4b", 1'b0, 0, 0, '0);

        // Reset in the middle of a scan
        do_write(0, 0, 8'h01);
        do_write(3, 2, 8'h33);
        do_write(5, 8, 8'hFF);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t5_live_zero", bus.strobe_out, '0);
        check("t5_busy_zero", LW'(bus.busy), '0);
        step();
        rst_n = 1'b1;
        model_clear();
        step();
        do_commit("t5", 1'b0, 0, 0, '0);

        // Commit with a write accepted in the same cycle
        do_commit("co_wr", 1'b1, 4, 8, 8'hF7);

`ifdef STROBE_LOADER_READBACK_EN
        do_write(2, 1, 8'h77);
        bus.rd_en   = 1'b1;
        bus.address = mk_addr(2, 1);
        step();
        bus.rd_en   = 1'b0;
        check("rd_data", LW'(bus.rd_data), LW'(8'h77));
        bus.rd_en   = 1'b1;
        bus.address = mk_addr(6, 1);
        step();
        bus.rd_en   = 1'b0;
        check("rd_oor_data", LW'(bus.rd_data), '0);
        check("rd_oor_err", LW'(bus.error), LW'(err_m));
`endif

        // Randomised traffic
        for (int it = 0; it < 60; it++) begin
            int r;
            int tgt;
            int idx;
            r = int'($urandom_range(0, 9));
            if (r < 7) begin
                tgt = int'($urandom_range(0, 7));
                idx = ($urandom_range(0, 15) == 0) ? 127 : int'($urandom_range(0, 9));
                do_write(tgt, idx, 8'($urandom));
                check("rnd_err", LW'(bus.error), LW'(err_m));
            end else if (r == 7) begin
                do_clear_err();
                check("rnd_err_clr", LW'(bus.error), LW'(err_m));
            end else begin
                do_commit("rnd", r == 9, int'($urandom_range(0, 5)), int'($urandom_range(0, 8)), 8'($urandom));
            end
        end
        do_commit("rnd_final", 1'b0, 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
